tl_intersection_ctrl: RTL and testbench

Intersection sequencer for a two-road crossing with a pedestrian phase. It drives main and side signal heads and latches pedestrian and side-street requests. It sequences the pedestrian walk display by issuing a one-cycle `walk_start` and waiting for its `walk_done`. It consumes the shared 1 Hz tick, so all phase timing is in whole seconds.

---
 rtl/tl_pkg.sv | 18 +
 rtl/tl_phase_timer.sv | 33 +++
 rtl/tl_intersection_ctrl.sv | 120 ++++++++++++
 tb/tb_tl_intersection_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection sequencer.
package tl_pkg;
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } tl_phase_t;

  localparam logic [2:0] RYG_RED = 3'b100;
  localparam logic [2:0] RYG_YEL = 3'b010;
  localparam logic [2:0] RYG_GRN = 3'b001;

  localparam int TMR_W = 8;
endpackage

// File: rtl/tl_phase_timer.sv
// Loadable seconds down-counter; expire pulses on the tick that takes rem from 1 to 0,
// after which rem rests at 0 and done stays high until the next load.
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             expire,
  output logic             done
);
  logic [TMR_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load)
      rem_d = value;
    else if (tick && (rem_q != '0))
      rem_d = rem_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rem_q <= RST_VAL;
    else     rem_q <= rem_d;
  end

  assign expire = tick && (rem_q == TMR_W'(1));
  assign done   = (rem_q == '0);
endmodule

// File: rtl/tl_intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian walk phase, all outputs registered.
// Optional walk watchdog enabled by defining TL_WALK_TIMEOUT_EN.
module tl_intersection_ctrl
  import tl_pkg::*;
#(
  parameter int MAIN_GREEN_SECS   = 20,
  parameter int SIDE_GREEN_SECS   = 10,
  parameter int YELLOW_SECS       = 3,
  parameter int ALL_RED_SECS      = 1,
  parameter int WALK_TIMEOUT_SECS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       ped_req,
  input  logic       side_sensor,
  input  logic       walk_done,
  output logic       walk_start,
  output logic [2:0] main_ryg,
  output logic [2:0] side_ryg,
  output logic       ped_wait_led,
  output logic       walk_fault,
  output logic [2:0] phase
);
  tl_phase_t        state_q, state_d;
  logic             ped_q, ped_d, side_q, side_d, ws_q, ws_d, fault_q, fault_d;
  logic [2:0]       main_q, main_d, sidel_q, sidel_d;
  logic             enter, t_exp, t_done, wd_exp;
  logic [TMR_W-1:0] t_val;

  function automatic logic [TMR_W-1:0] secs_for(tl_phase_t s);
    case (s)
      MAIN_GREEN:             return TMR_W'(MAIN_GREEN_SECS);
      MAIN_YELLOW,
      SIDE_YELLOW:            return TMR_W'(YELLOW_SECS);
      ALL_RED_A, ALL_RED_B:   return TMR_W'(ALL_RED_SECS);
      SIDE_GREEN:             return TMR_W'(SIDE_GREEN_SECS);
      default:                return '0;
    endcase
  endfunction

  tl_phase_timer #(.RST_VAL(TMR_W'(MAIN_GREEN_SECS))) u_phase_tmr (
    .clk(clk), .rst(rst), .tick(tick_1hz), .load(enter), .value(t_val),
    .expire(t_exp), .done(t_done)
  );

`ifdef TL_WALK_TIMEOUT_EN
  logic wd_raw, unused_wd_done;
  tl_phase_timer #(.RST_VAL('0)) u_walk_wd (
    .clk(clk), .rst(rst), .tick(tick_1hz), .load(ws_d),
    .value(TMR_W'(WALK_TIMEOUT_SECS)), .expire(wd_raw), .done(unused_wd_done)
  );
  // The watchdog keeps counting after WALK exits; only its expiry inside WALK matters.
  assign wd_exp = wd_raw && (state_q == WALK);
`else
  logic unused_wd;
  assign unused_wd = ^TMR_W'(WALK_TIMEOUT_SECS);
  assign wd_exp    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN:  if ((t_done || t_exp) && (ped_q || side_q)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (t_exp) state_d = ALL_RED_A;
      ALL_RED_A:   if (t_exp) state_d = ped_q ? WALK : SIDE_GREEN;
      WALK:        if (walk_done || wd_exp) state_d = side_q ? SIDE_GREEN : MAIN_GREEN;
      SIDE_GREEN:  if (t_exp) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (t_exp) state_d = ALL_RED_B;
      ALL_RED_B:   if (t_exp) state_d = MAIN_GREEN;
      default:     state_d = MAIN_GREEN;
    endcase

    enter   = (state_d != state_q);
    t_val   = secs_for(state_d);
    ws_d    = enter && (state_d == WALK);
    // A request landing on the WALK entry edge survives the clear.
    ped_d   = ped_req || (ped_q && !ws_d);
    side_d  = (enter && (state_d == SIDE_GREEN)) ? 1'b0
            : (side_q || (side_sensor && (state_q != SIDE_GREEN)));
    fault_d = fault_q || ((state_q == WALK) && !walk_done && wd_exp);

    main_d  = RYG_RED;
    sidel_d = RYG_RED;
    case (state_d)
      MAIN_GREEN:  main_d  = RYG_GRN;
      MAIN_YELLOW: main_d  = RYG_YEL;
      SIDE_GREEN:  sidel_d = RYG_GRN;
      SIDE_YELLOW: sidel_d = RYG_YEL;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MAIN_GREEN;
      ped_q   <= 1'b0;
      side_q  <= 1'b0;
      ws_q    <= 1'b0;
      fault_q <= 1'b0;
      main_q  <= RYG_GRN;
      sidel_q <= RYG_RED;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
      side_q  <= side_d;
      ws_q    <= ws_d;
      fault_q <= fault_d;
      main_q  <= main_d;
      sidel_q <= sidel_d;
    end
  end

  assign walk_start   = ws_q;
  assign main_ryg     = main_q;
  assign side_ryg     = sidel_q;
  assign ped_wait_led = ped_q;
  assign walk_fault   = fault_q;
  assign phase        = state_q;
endmodule

// File: tb/tb_tl_intersection_ctrl.sv
// Scoreboard bench: a phase/seconds reference model predicts every cycle's outputs,
// a monitor process pops and compares them against the DUT.
module tb_tl_intersection_ctrl;
  localparam int MG = 4, SG = 3, YL = 2, AR = 1, WT = 5;

  logic clk = 1'b0, rst = 1'b0, tick_1hz = 1'b0, ped_req = 1'b0;
  logic side_sensor = 1'b0, walk_done = 1'b0;
  logic walk_start, ped_wait_led, walk_fault;
  logic [2:0] main_ryg, side_ryg, phase;

  always #5 clk = ~clk;

  tl_intersection_ctrl #(
    .MAIN_GREEN_SECS(MG), .SIDE_GREEN_SECS(SG), .YELLOW_SECS(YL),
    .ALL_RED_SECS(AR), .WALK_TIMEOUT_SECS(WT)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .ped_req(ped_req),
    .side_sensor(side_sensor), .walk_done(walk_done), .walk_start(walk_start),
    .main_ryg(main_ryg), .side_ryg(side_ryg), .ped_wait_led(ped_wait_led),
    .walk_fault(walk_fault), .phase(phase)
  );

  typedef struct {
    logic [2:0] m, s, ph;
    logic       ws, led, flt;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 0;
  int   nvec = 0, nmis = 0, cnt = 0;

  // Reference model: phase number, seconds elapsed in phase, walk seconds, request flags.
  int m_st = 0, m_e = 0, m_w = 0;
  bit m_ped = 0, m_side = 0, m_ws = 0, m_flt = 0;

  function automatic int dur(int st);
    case (st)
      0: return MG;
      1, 5: return YL;
      2, 6: return AR;
      4: return SG;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] lmain(int st);
    return (st == 0) ? 3'b001 : (st == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] lside(int st);
    return (st == 4) ? 3'b001 : (st == 5) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_step(bit r, bit t, bit p, bit s, bit wd);
    int nx;
    bit expn, to;
    if (r) begin
      m_st = 0; m_e = 0; m_w = 0;
      m_ped = 0; m_side = 0; m_ws = 0; m_flt = 0;
      return;
    end
    nx   = m_st;
    to   = 0;
    expn = t && (m_e + 1 == dur(m_st));
    case (m_st)
      0: if ((m_e >= MG || expn) && (m_ped || m_side)) nx = 1;
      1: if (expn) nx = 2;
      2: if (expn) nx = m_ped ? 3 : 4;
      3: begin
`ifdef TL_WALK_TIMEOUT_EN
        if (t) begin m_w++; to = (m_w >= WT); end
`endif
        if (wd) nx = m_side ? 4 : 0;
        else if (to) begin nx = m_side ? 4 : 0; m_flt = 1; end
      end
      4: if (expn) nx = 5;
      5: if (expn) nx = 6;
      6: if (expn) nx = 0;
      default: nx = 0;
    endcase
    m_ws  = (nx == 3) && (m_st != 3);
    m_ped = p || (m_ped && !m_ws);
    if (nx == 4 && m_st != 4) m_side = 0;
    else m_side = m_side || (s && m_st != 4);
    if (nx != m_st) begin m_e = 0; m_w = 0; end
    else if (t && m_e < dur(m_st)) m_e++;
    m_st = nx;
  endtask

  // One clock of stimulus; the prediction for this edge is queued once the edge has passed.
  task automatic cyc(bit r, bit p, bit s, bit wd);
    @(posedge clk); #1;
    if (have_pend) q.push_back(pend);
    rst = r; ped_req = p; side_sensor = s; walk_done = wd;
    tick_1hz = (cnt % 10 == 9);
    cnt++;
    model_step(r, tick_1hz, p, s, wd);
    pend = '{lmain(m_st), lside(m_st), 3'(m_st), m_ws, m_ped, m_flt};
    have_pend = 1;
  endtask

  task automatic to_walk();
    for (int i = 0; i < 500 && m_st != 3; i++) cyc(0, 0, 0, 0);
    if (m_st != 3) begin
      nvec++; nmis++;
      $display("FAIL to_walk: phase %0d after cycle budget, required 3", m_st);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if ({main_ryg, side_ryg, phase, walk_start, ped_wait_led, walk_fault} !==
            {e.m, e.s, e.ph, e.ws, e.led, e.flt}) begin
          nmis++;
          $display("FAIL vec %0d: got main=%b side=%b phase=%0d ws=%b led=%b flt=%b, expected main=%b side=%b phase=%0d ws=%b led=%b flt=%b",
                   nvec, main_ryg, side_ryg, phase, walk_start, ped_wait_led, walk_fault,
                   e.m, e.s, e.ph, e.ws, e.led, e.flt);
        end
      end
    end
  end

  initial begin
    bit sl;
    // Idle after reset: main stays green.
    cyc(1, 0, 0, 0);
    repeat (200) cyc(0, 0, 0, 0);

    // Side request only.
    cyc(1, 0, 0, 0); cnt = 0;
    repeat (10) cyc(0, 0, 0, 0);
    repeat (15) cyc(0, 0, 1, 0);
    repeat (150) cyc(0, 0, 0, 0);

    // Pedestrian request only; walk_done 8 cycles into WALK.
    cyc(1, 0, 0, 0); cnt = 0;
    repeat (20) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    to_walk();
    repeat (8) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (60) cyc(0, 0, 0, 0);

    // Both requests; second ped_req on the walk_start cycle.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    to_walk();
    cyc(0, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (250) cyc(0, 0, 0, 0);

    // No walk_done: watchdog exit or indefinite WALK, then reset clears the fault.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    to_walk();
    repeat (520) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);

    // Reset mid-WALK followed by a stray walk_done.
    cyc(0, 1, 0, 0);
    to_walk();
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (20) cyc(0, 0, 0, 0);

    // Randomized traffic.
    cyc(1, 0, 0, 0);
    sl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) sl = !sl;
      cyc(($urandom_range(0, 1500) == 0),
          ($urandom_range(0, 40) == 0),
          sl,
          (m_st == 3 && $urandom_range(0, 15) == 0) || ($urandom_range(0, 200) == 0));
    end

    @(posedge clk); #1;
    if (have_pend) q.push_back(pend);
    have_pend = 0;
    repeat (2) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
